// File: rtl/cm_status_reporter_pkg.sv
// Shared encodings for the config-channel response path: frame types and reporter FSM states.
package cm_status_reporter_pkg;

  localparam int TYPE_W = 2;

  localparam logic [TYPE_W-1:0] TYPE_ERROR        = 2'b10;
  localparam logic [TYPE_W-1:0] TYPE_NOTIFICATION = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SEND_HI = 2'd2,
    ST_SEND_LO = 2'd3
  } state_t;

endpackage

// File: rtl/cm_event_slot.sv
// One pending-event slot: code plus status snapshot, loaded by a valid pulse, freed when the frame loads.
// Latency 1 cycle load-to-pending; no backpressure, a repeat load overwrites and flags overrun.
module cm_event_slot #(
  parameter int CODE_W = 3,
  parameter int SNAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CODE_W-1:0] code_in,
  input  logic [SNAP_W-1:0] snap_in,
  output logic              pending,
  output logic [CODE_W-1:0] code,
  output logic [SNAP_W-1:0] snap,
  output logic              overrun
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      code    <= '0;
      snap    <= '0;
      overrun <= 1'b0;
    end else begin
      // A slot being copied out this cycle is not lost, so a new event then is not an overrun.
      overrun <= load & pending & ~clear;
      if (load) begin
        pending <= 1'b1;
        code    <= code_in;
        snap    <= snap_in;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cm_status_reporter.sv
// Turns config-manager error/notification pulses into 2-byte response frames for the UART TX FIFO.
// Pulse to byte0 write is 3 cycles, byte1 one later; Full stalls the FSM, no write follows a Full cycle.
module cm_status_reporter
  import cm_status_reporter_pkg::*;
#(
  parameter int UART_DATA_WIDTH           = 8,
  parameter int CONFIG_STATUS_WIDTH       = 8,
  parameter int CONFIG_NOTIFICATION_WIDTH = 3,
  parameter int CONFIG_ERROR_WIDTH        = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
  input  logic                                 Config_Notification_Valid,
  input  logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
  input  logic                                 Error_Valid,
  input  logic [CONFIG_STATUS_WIDTH-1:0]       Config_Status,
  input  logic                                 Full,
  output logic [UART_DATA_WIDTH-1:0]           TXD_Data,
  output logic                                 Wr_En,
  output logic                                 Busy,
  output logic                                 Overrun
);

  localparam int CODE_W = (CONFIG_ERROR_WIDTH > CONFIG_NOTIFICATION_WIDTH) ?
                          CONFIG_ERROR_WIDTH : CONFIG_NOTIFICATION_WIDTH;

  state_t                           state;
  logic                             sel_err;
  logic [UART_DATA_WIDTH-1:0]       frame_hi;
  logic [UART_DATA_WIDTH-1:0]       frame_lo;

  logic [CODE_W-1:0]                err_code_in;
  logic [CODE_W-1:0]                ntf_code_in;
  logic                             err_pending;
  logic                             ntf_pending;
  logic [CODE_W-1:0]                err_code;
  logic [CODE_W-1:0]                ntf_code;
  logic [CONFIG_STATUS_WIDTH-1:0]   err_snap;
  logic [CONFIG_STATUS_WIDTH-1:0]   ntf_snap;
  logic                             err_overrun;
  logic                             ntf_overrun;
  logic                             clear_err;
  logic                             clear_ntf;

  assign err_code_in = CODE_W'(Config_Error);
  assign ntf_code_in = CODE_W'(Config_Notification);

  assign clear_err = (state == ST_LOAD) &  sel_err;
  assign clear_ntf = (state == ST_LOAD) & ~sel_err;

  cm_event_slot #(
    .CODE_W (CODE_W),
    .SNAP_W (CONFIG_STATUS_WIDTH)
  ) u_err_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (Error_Valid),
    .clear   (clear_err),
    .code_in (err_code_in),
    .snap_in (Config_Status),
    .pending (err_pending),
    .code    (err_code),
    .snap    (err_snap),
    .overrun (err_overrun)
  );

  cm_event_slot #(
    .CODE_W (CODE_W),
    .SNAP_W (CONFIG_STATUS_WIDTH)
  ) u_ntf_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (Config_Notification_Valid),
    .clear   (clear_ntf),
    .code_in (ntf_code_in),
    .snap_in (Config_Status),
    .pending (ntf_pending),
    .code    (ntf_code),
    .snap    (ntf_snap),
    .overrun (ntf_overrun)
  );

  // byte0 layout: type in the top two bits, code right-aligned, zeros between.
  function automatic logic [UART_DATA_WIDTH-1:0] make_hdr(input logic [TYPE_W-1:0] t,
                                                          input logic [CODE_W-1:0] c);
    logic [UART_DATA_WIDTH-1:0] h;
    h = '0;
    h[UART_DATA_WIDTH-1 -: TYPE_W] = t;
    h[CODE_W-1:0] = c;
    return h;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel_err  <= 1'b0;
      frame_hi <= '0;
      frame_lo <= '0;
      TXD_Data <= '0;
      Wr_En    <= 1'b0;
    end else begin
      Wr_En <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (err_pending) begin
            sel_err <= 1'b1;
            state   <= ST_LOAD;
          end else if (ntf_pending) begin
            sel_err <= 1'b0;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (sel_err) begin
            frame_hi <= make_hdr(TYPE_ERROR, err_code);
            frame_lo <= UART_DATA_WIDTH'(err_snap);
          end else begin
            frame_hi <= make_hdr(TYPE_NOTIFICATION, ntf_code);
            frame_lo <= UART_DATA_WIDTH'(ntf_snap);
          end
          state <= ST_SEND_HI;
        end
        ST_SEND_HI: begin
          if (!Full) begin
            Wr_En    <= 1'b1;
            TXD_Data <= frame_hi;
            state    <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (!Full) begin
            Wr_En    <= 1'b1;
            TXD_Data <= frame_lo;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy    = err_pending | ntf_pending | (state != ST_IDLE);
  assign Overrun = err_overrun | ntf_overrun;

endmodule

// File: tb/tb_cm_status_reporter.sv
// Scoreboard bench for cm_status_reporter: expected bytes queued at stimulus, checked on every Wr_En.
module tb_cm_status_reporter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] Config_Notification = '0;
  logic       Config_Notification_Valid = 1'b0;
  logic [2:0] Config_Error = '0;
  logic       Error_Valid = 1'b0;
  logic [7:0] Config_Status = '0;
  logic       Full = 1'b0;
  logic [7:0] TXD_Data;
  logic       Wr_En;
  logic       Busy;
  logic       Overrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];
  int         wr_cyc[$];

  cm_status_reporter dut (
    .clk                       (clk),
    .rst                       (rst),
    .Config_Notification       (Config_Notification),
    .Config_Notification_Valid (Config_Notification_Valid),
    .Config_Error              (Config_Error),
    .Error_Valid               (Error_Valid),
    .Config_Status             (Config_Status),
    .Full                      (Full),
    .TXD_Data                  (TXD_Data),
    .Wr_En                     (Wr_En),
    .Busy                      (Busy),
    .Overrun                   (Overrun)
  );

  always #5 clk = ~clk;

  // Write monitor: every Wr_En pops one expected byte and must not follow a Full edge.
  always begin : mon
    logic       full_at_edge;
    logic [7:0] e;
    @(posedge clk);
    full_at_edge = Full;
    cyc++;
    #2;
    if (Wr_En) begin
      wr_cyc.push_back(cyc);
      checks++;
      if (full_at_edge) begin
        errors++;
        $display("FAIL wr_after_full: Wr_En=1 at cycle %0d, required 0 after Full=1", cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: TXD_Data=%h at cycle %0d, required no write", TXD_Data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (TXD_Data !== e) begin
          errors++;
          $display("FAIL tx_byte: TXD_Data=%h at cycle %0d, required %h", TXD_Data, cyc, e);
        end
      end
    end
  end

  task automatic pulse_ntf(input logic [2:0] c, input logic [7:0] s);
    Config_Notification       = c;
    Config_Status             = s;
    Config_Notification_Valid = 1'b1;
    @(negedge clk);
    Config_Notification_Valid = 1'b0;
  endtask

  task automatic pulse_err(input logic [2:0] c, input logic [7:0] s);
    Config_Error  = c;
    Config_Status = s;
    Error_Valid   = 1'b1;
    @(negedge clk);
    Error_Valid   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!Busy && exp_q.size() == 0) break;
    end
    checks++;
    if (Busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: Busy=%b pending_bytes=%0d, required Busy=0 and 0 bytes",
               name, Busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (TXD_Data !== 8'h00) begin errors++; $display("FAIL reset_txd: %h required 00", TXD_Data); end
    checks++; if (Wr_En !== 1'b0) begin errors++; $display("FAIL reset_wr_en: %b required 0", Wr_En); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b required 0", Busy); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: %b required 0", Overrun); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_ntf();
    wr_cyc.delete();
    exp_q.push_back(8'h42);
    exp_q.push_back(8'hA5);
    pulse_ntf(3'd2, 8'hA5);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL single_busy: %b required 1", Busy); end
    repeat (2) @(negedge clk);
    checks++; if (Wr_En !== 1'b0) begin errors++; $display("FAIL single_early_wr: %b required 0", Wr_En); end
    @(negedge clk);
    checks++; if (Wr_En !== 1'b1) begin errors++; $display("FAIL single_byte0_lat: %b required 1", Wr_En); end
    @(negedge clk);
    checks++; if (Wr_En !== 1'b1) begin errors++; $display("FAIL single_byte1_lat: %b required 1", Wr_En); end
    @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: %b required 0", Busy); end
    checks++; if (TXD_Data !== 8'hA5) begin errors++; $display("FAIL single_hold: %h required a5", TXD_Data); end
    wait_idle("single");
  endtask

  task automatic test_both_same_cycle();
    int p;
    wr_cyc.delete();
    exp_q.push_back(8'h81); exp_q.push_back(8'h3C);
    exp_q.push_back(8'h44); exp_q.push_back(8'h3C);
    Config_Notification       = 3'd4;
    Config_Notification_Valid = 1'b1;
    pulse_err(3'd1, 8'h3C);
    Config_Notification_Valid = 1'b0;
    p = cyc;
    wait_idle("both");
    checks++;
    if (wr_cyc.size() != 4) begin
      errors++; $display("FAIL both_writes: %0d writes, required 4", wr_cyc.size());
    end else begin
      checks++;
      if (wr_cyc[0] != p + 3) begin errors++; $display("FAIL both_latency: byte0 at +%0d, required +3", wr_cyc[0] - p); end
      checks++;
      if (wr_cyc[2] - wr_cyc[1] != 3) begin errors++; $display("FAIL both_gap: %0d cycles, required 3", wr_cyc[2] - wr_cyc[1]); end
    end
  endtask

  task automatic test_full_stall();
    wr_cyc.delete();
    Full = 1'b1;
    exp_q.push_back(8'h85);
    exp_q.push_back(8'h11);
    pulse_err(3'd5, 8'h11);
    Config_Status = 8'hFF;
    repeat (8) @(negedge clk);
    checks++; if (wr_cyc.size() != 0) begin errors++; $display("FAIL stall_writes: %0d required 0", wr_cyc.size()); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL stall_busy: %b required 1", Busy); end
    Full = 1'b0;
    @(negedge clk);
    checks++; if (Wr_En !== 1'b1) begin errors++; $display("FAIL stall_release: %b required 1", Wr_En); end
    Full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (Wr_En !== 1'b0) begin errors++; $display("FAIL stall_lo_%0d: Wr_En=%b required 0", i, Wr_En); end
    end
    Full = 1'b0;
    wait_idle("stall");
    checks++; if (wr_cyc.size() != 2) begin errors++; $display("FAIL stall_total: %0d writes required 2", wr_cyc.size()); end
  endtask

  task automatic test_overrun();
    wr_cyc.delete();
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h77);
    pulse_ntf(3'd1, 8'h10);
    pulse_ntf(3'd3, 8'h77);
    checks++; if (Overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: %b required 1", Overrun); end
    @(negedge clk);
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL overrun_width: %b required 0", Overrun); end
    wait_idle("overrun");
    checks++; if (wr_cyc.size() != 2) begin errors++; $display("FAIL overrun_frames: %0d writes required 2", wr_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    wr_cyc.delete();
    exp_q.push_back(8'h42); exp_q.push_back(8'hA5);
    exp_q.push_back(8'h46); exp_q.push_back(8'h5A);
    pulse_ntf(3'd2, 8'hA5);
    repeat (3) @(negedge clk);
    checks++; if (Wr_En !== 1'b1) begin errors++; $display("FAIL b2b_byte0: %b required 1", Wr_En); end
    pulse_ntf(3'd6, 8'h5A);
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: %b required 0", Overrun); end
    wait_idle("b2b");
    checks++;
    if (wr_cyc.size() != 4) begin
      errors++; $display("FAIL b2b_writes: %0d writes, required 4", wr_cyc.size());
    end else begin
      checks++;
      if (wr_cyc[2] - wr_cyc[1] != 3) begin errors++; $display("FAIL b2b_gap: %0d cycles, required 3", wr_cyc[2] - wr_cyc[1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    wr_cyc.delete();
    exp_q.push_back(8'h40);
    pulse_ntf(3'd0, 8'h99);
    repeat (3) @(negedge clk);
    checks++; if (Wr_En !== 1'b1) begin errors++; $display("FAIL rstmid_byte0: %b required 1", Wr_En); end
    Full = 1'b1;
    pulse_err(3'd7, 8'h01);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy: %b required 1", Busy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (TXD_Data !== 8'h00) begin errors++; $display("FAIL rstmid_txd: %h required 00", TXD_Data); end
    checks++; if (Wr_En !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en: %b required 0", Wr_En); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_clr: %b required 0", Busy); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: %b required 0", Overrun); end
    @(negedge clk);
    rst  = 1'b0;
    Full = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (wr_cyc.size() != 1) begin errors++; $display("FAIL rstmid_writes: %0d writes required 1", wr_cyc.size()); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: Busy=%b required 0", Busy); end
  endtask

  initial begin
    test_reset();
    test_single_ntf();
    test_both_same_cycle();
    test_full_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
